// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding word requests,
// and buffers epoch-tagged responses in a small FIFO toward decode.
module fetch_pc_unit #(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    req_addr;
    logic               req_epoch;
    logic               epoch;
    logic               outstanding;

    logic [XLEN-1:0]    q_pc   [QDEPTH];
    logic [XLEN-1:0]    q_data [QDEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   free;

    logic               redirect;
    logic [XLEN-1:0]    target_aligned;
    logic               pop;
    logic               push;
    logic               hs;
    logic               rsp_take;
    logic               latch;
    logic               pc_inc;
    logic [XLEN-1:0]    latch_addr;
    logic               latch_epoch;

    assign redirect       = next_pc_src;
    assign target_aligned = {branch_target[XLEN-1:2], 2'b00};
    assign inst_valid     = (count != '0);
    assign pop            = inst_valid && inst_ready;
    assign free           = CNT_W'(QDEPTH) - count - CNT_W'(outstanding);

    // A redirect in the same cycle as a new latch points the request at the new stream.
    assign latch_addr  = redirect ? target_aligned : fetch_pc;
    assign latch_epoch = redirect ? ~epoch : epoch;
    // A stale request completing after a redirect must not advance the new stream's PC.
    assign pc_inc      = hs && !redirect && (req_epoch == epoch);

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = req_addr;
    assign inst           = q_data[head];
    assign inst_pc        = q_pc[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and queue-occupancy decisions.
    always_comb begin
        state_next = state;
        latch      = 1'b0;
        hs         = 1'b0;
        rsp_take   = 1'b0;
        push       = 1'b0;
        count_next = count;
        case (state)
            S_IDLE: begin
                if ((free != '0) || redirect) begin
                    state_next = S_REQ;
                    latch      = 1'b1;
                end
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_next = S_WAIT;
                    hs         = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    rsp_take = 1'b1;
                    push     = !redirect && (req_epoch == epoch);
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
        if (rsp_take) begin
            if (count_next != CNT_W'(QDEPTH)) begin
                state_next = S_REQ;
                latch      = 1'b1;
            end else begin
                state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            req_addr     <= RESET_PC;
            req_epoch    <= 1'b0;
            epoch        <= 1'b0;
            outstanding  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= target_aligned;
                epoch    <= ~epoch;
            end else if (pc_inc) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (latch) begin
                req_addr  <= latch_addr;
                req_epoch <= latch_epoch;
            end
            if (hs) begin
                outstanding <= 1'b1;
            end else if (rsp_take) begin
                outstanding <= 1'b0;
            end
            misalign_err <= redirect && (branch_target[1:0] != 2'b00);
        end
    end

    // Instruction FIFO; a redirect flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_pc[tail]   <= req_addr;
                q_data[tail] <= imem_rsp_data;
                tail         <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CNT_W'(QDEPTH))));

endmodule
